// File: rtl/interpretador_serial_param.sv
// interpretador_serial_param: decodes UART bytes into command channels and a floor-request FIFO
module interpretador_serial_param #(
  parameter int               N_CMD          = 3,
  parameter logic [N_CMD-1:0] MASCARA_PULSO  = '0,
  parameter int               N_ANDARES      = 4,
  parameter int               FIFO_DEPTH     = 4,
  parameter int               TIMEOUT_CICLOS = 0,
  parameter int               ERR_W          = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       dados_serial_recebido,
  input  logic             dado_valido,
  input  logic             destino_consumido,
  output logic [N_CMD-1:0] comandos,
  output logic [6:0]       destino,
  output logic             destino_disponivel,
  output logic             fifo_cheia,
  output logic             erro_quadro,
  output logic [ERR_W-1:0] contagem_erros,
  output logic             timeout_serial
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CICLOS + 2);
  localparam logic [6:0] RESERVADO = ~((7'd1 << N_CMD) - 7'd1);
  logic [6:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    ocupacao;
  logic [N_CMD-1:0] nivel, pulso;
  logic [TW-1:0]    ociosos;
  logic             cmd_ok, dest_ok, pop, push, rejeita, expira;
  assign destino_disponivel = ocupacao != '0;
  assign fifo_cheia = ocupacao == CW'(FIFO_DEPTH);
  assign destino = destino_disponivel ? mem[rd_ptr] : 7'd0;
  assign comandos = nivel | pulso;
  // Frame classification; a full FIFO only accepts a push when the head leaves in the same cycle
  always_comb begin
    cmd_ok = dado_valido && dados_serial_recebido[7] && (dados_serial_recebido[6:0] & RESERVADO) == 7'd0;
    dest_ok = dado_valido && !dados_serial_recebido[7] && {1'b0, dados_serial_recebido[6:0]} < 8'(N_ANDARES);
    pop = destino_consumido && destino_disponivel;
    push = dest_ok && (!fifo_cheia || pop);
    rejeita = dado_valido && !cmd_ok && !push;
    expira = TIMEOUT_CICLOS != 0 && !dado_valido && ociosos == TW'(TIMEOUT_CICLOS - 1);
  end
  // Destination FIFO with first-word fall-through head
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ocupacao <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) mem[wr_ptr] <= dados_serial_recebido[6:0];
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      ocupacao <= ocupacao + CW'(push) - CW'(pop);
    end
  end
  // Level channels hold until the next valid command or link loss; pulse channels last one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nivel <= '0;
      pulso <= '0;
    end else begin
      pulso <= cmd_ok ? dados_serial_recebido[N_CMD-1:0] & MASCARA_PULSO : '0;
      nivel <= cmd_ok ? dados_serial_recebido[N_CMD-1:0] & ~MASCARA_PULSO : expira ? '0 : nivel;
    end
  end
  // Rejected-frame pulse and saturating counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      erro_quadro <= 1'b0;
      contagem_erros <= '0;
    end else begin
      erro_quadro <= rejeita;
      contagem_erros <= contagem_erros + ERR_W'(rejeita && contagem_erros != '1);
    end
  end
  // Idle counter parks at the limit so link loss is reported once per silence
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ociosos <= '0;
      timeout_serial <= 1'b0;
    end else begin
      ociosos <= dado_valido ? '0 : ociosos == TW'(TIMEOUT_CICLOS) ? ociosos : ociosos + 1'b1;
      timeout_serial <= expira;
    end
  end
endmodule

// File: tb/tb_interpretador_serial_param.sv
// tb_interpretador_serial_param: scenario tasks with queue-based expectations for the serial interpreter
module tb_interpretador_serial_param;
  logic       clock = 1'b0, reset = 1'b0;
  logic [7:0] dados = 8'd0;
  logic       dado_valido = 1'b0, destino_consumido = 1'b0;
  logic [2:0] comandos;
  logic [6:0] destino;
  logic       destino_disponivel, fifo_cheia, erro_quadro, timeout_serial;
  logic [2:0] contagem_erros;
  int         checks = 0, errors = 0, erros_esp = 0;
  logic [6:0] fila [$];
  logic [2:0] q_cmd [$];

  interpretador_serial_param #(
    .N_CMD(3), .MASCARA_PULSO(3'b001), .N_ANDARES(4),
    .FIFO_DEPTH(4), .TIMEOUT_CICLOS(10), .ERR_W(3)
  ) dut (
    .clock(clock), .reset(reset),
    .dados_serial_recebido(dados), .dado_valido(dado_valido),
    .destino_consumido(destino_consumido),
    .comandos(comandos), .destino(destino),
    .destino_disponivel(destino_disponivel), .fifo_cheia(fifo_cheia),
    .erro_quadro(erro_quadro), .contagem_erros(contagem_erros),
    .timeout_serial(timeout_serial)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] cnt_esp();
    return erros_esp > 7 ? 3'd7 : 3'(erros_esp);
  endfunction

  task automatic passo(input logic v, input logic [7:0] b, input logic c);
    dado_valido = v;
    dados = b;
    destino_consumido = c;
    @(posedge clock);
    #1;
    dado_valido = 1'b0;
    destino_consumido = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({comandos, destino, destino_disponivel, fifo_cheia, erro_quadro, contagem_erros, timeout_serial} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got cmd=%b dest=%0d disp=%b cheia=%b erro=%b cnt=%0d tmo=%b expected all 0",
               comandos, destino, destino_disponivel, fifo_cheia, erro_quadro, contagem_erros, timeout_serial);
    end
    reset = 1'b1;
    passo(1'b0, 8'h00, 1'b0);
    checks++;
    if ({comandos, destino_disponivel, erro_quadro, contagem_erros} !== '0) begin
      errors++;
      $display("FAIL reset_release: got cmd=%b disp=%b erro=%b cnt=%0d expected all 0",
               comandos, destino_disponivel, erro_quadro, contagem_erros);
    end
  endtask

  task automatic test_comandos;
    logic [8:0] est [8] = '{9'h187, 9'h000, 9'h000, 9'h180, 9'h182, 9'h181, 9'h000, 9'h186};
    logic [2:0] esp [8] = '{3'b111, 3'b110, 3'b110, 3'b000, 3'b010, 3'b001, 3'b000, 3'b110};
    logic [2:0] e;
    for (int i = 0; i < 8; i++) begin
      q_cmd.push_back(esp[i]);
      passo(est[i][8], est[i][7:0], 1'b0);
      e = q_cmd.pop_front();
      checks++;
      if (comandos !== e) begin
        errors++;
        $display("FAIL cmd_step%0d: got %b expected %b", i, comandos, e);
      end
      checks++;
      if (erro_quadro !== 1'b0) begin
        errors++;
        $display("FAIL cmd_noerr%0d: got %b expected 0", i, erro_quadro);
      end
    end
  endtask

  task automatic test_erros;
    logic [7:0] b [5] = '{8'h88, 8'h05, 8'hC0, 8'h04, 8'h03};
    bit         ruim [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      passo(1'b1, b[i], 1'b0);
      if (ruim[i]) erros_esp++;
      else fila.push_back(b[i][6:0]);
      checks++;
      if (erro_quadro !== ruim[i] || contagem_erros !== cnt_esp()) begin
        errors++;
        $display("FAIL err_byte%0h: got erro=%b cnt=%0d expected erro=%b cnt=%0d",
                 b[i], erro_quadro, contagem_erros, ruim[i], cnt_esp());
      end
      checks++;
      if (comandos !== 3'b110 || destino_disponivel !== (fila.size() != 0)) begin
        errors++;
        $display("FAIL err_side%0h: got cmd=%b disp=%b expected cmd=110 disp=%b",
                 b[i], comandos, destino_disponivel, fila.size() != 0);
      end
    end
    checks++;
    if (destino !== fila[0]) begin
      errors++;
      $display("FAIL err_dest: got %0d expected %0d", destino, fila[0]);
    end
    passo(1'b0, 8'h00, 1'b1);
    void'(fila.pop_front());
    checks++;
    if (destino_disponivel !== 1'b0 || erro_quadro !== 1'b0) begin
      errors++;
      $display("FAIL err_drain: got disp=%b erro=%b expected 0 0", destino_disponivel, erro_quadro);
    end
  endtask

  task automatic test_fifo;
    logic [6:0] andares [4] = '{7'd1, 7'd2, 7'd3, 7'd0};
    for (int i = 0; i < 4; i++) begin
      passo(1'b1, {1'b0, andares[i]}, 1'b0);
      fila.push_back(andares[i]);
      checks++;
      if (destino !== fila[0] || fifo_cheia !== (i == 3) || destino_disponivel !== 1'b1) begin
        errors++;
        $display("FAIL fifo_push%0d: got dest=%0d cheia=%b disp=%b expected dest=%0d cheia=%b disp=1",
                 i, destino, fifo_cheia, destino_disponivel, fila[0], i == 3);
      end
    end
    passo(1'b1, 8'h02, 1'b0);
    erros_esp++;
    checks++;
    if (erro_quadro !== 1'b1 || contagem_erros !== cnt_esp() || fifo_cheia !== 1'b1) begin
      errors++;
      $display("FAIL fifo_overflow: got erro=%b cnt=%0d cheia=%b expected 1 %0d 1",
               erro_quadro, contagem_erros, fifo_cheia, cnt_esp());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (destino !== fila[0]) begin
        errors++;
        $display("FAIL fifo_pop%0d: got %0d expected %0d", i, destino, fila[0]);
      end
      passo(1'b0, 8'h00, 1'b1);
      void'(fila.pop_front());
    end
    checks++;
    if (destino_disponivel !== 1'b0 || destino !== 7'd0) begin
      errors++;
      $display("FAIL fifo_empty: got disp=%b dest=%0d expected 0 0", destino_disponivel, destino);
    end
    passo(1'b0, 8'h00, 1'b1);
    checks++;
    if (destino_disponivel !== 1'b0 || erro_quadro !== 1'b0 || contagem_erros !== cnt_esp()) begin
      errors++;
      $display("FAIL fifo_pop_empty: got disp=%b erro=%b cnt=%0d expected 0 0 %0d",
               destino_disponivel, erro_quadro, contagem_erros, cnt_esp());
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] andares [4] = '{7'd2, 7'd1, 7'd0, 7'd1};
    for (int i = 0; i < 4; i++) begin
      passo(1'b1, {1'b0, andares[i]}, 1'b0);
      fila.push_back(andares[i]);
    end
    passo(1'b1, 8'h03, 1'b1);
    void'(fila.pop_front());
    fila.push_back(7'd3);
    checks++;
    if (erro_quadro !== 1'b0 || fifo_cheia !== 1'b1 || destino !== fila[0]) begin
      errors++;
      $display("FAIL b2b_full: got erro=%b cheia=%b dest=%0d expected 0 1 %0d",
               erro_quadro, fifo_cheia, destino, fila[0]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (destino !== fila[0]) begin
        errors++;
        $display("FAIL b2b_drain%0d: got %0d expected %0d", i, destino, fila[0]);
      end
      passo(1'b0, 8'h00, 1'b1);
      void'(fila.pop_front());
    end
    passo(1'b1, 8'h02, 1'b1);
    fila.push_back(7'd2);
    checks++;
    if (destino_disponivel !== 1'b1 || destino !== fila[0] || erro_quadro !== 1'b0 || fifo_cheia !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: got disp=%b dest=%0d erro=%b cheia=%b expected 1 %0d 0 0",
               destino_disponivel, destino, erro_quadro, fifo_cheia, fila[0]);
    end
    passo(1'b0, 8'h00, 1'b1);
    void'(fila.pop_front());
    checks++;
    if (destino_disponivel !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final: got disp=%b expected 0", destino_disponivel);
    end
  endtask

  task automatic test_saturacao;
    for (int i = 0; i < 6; i++) begin
      passo(1'b1, 8'h7F, 1'b0);
      erros_esp++;
      checks++;
      if (erro_quadro !== 1'b1 || contagem_erros !== cnt_esp()) begin
        errors++;
        $display("FAIL sat%0d: got erro=%b cnt=%0d expected 1 %0d", i, erro_quadro, contagem_erros, cnt_esp());
      end
    end
  endtask

  task automatic test_timeout;
    logic [2:0] e;
    passo(1'b1, 8'h02, 1'b0);
    fila.push_back(7'd2);
    passo(1'b1, 8'h86, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      passo(1'b0, 8'h00, 1'b0);
      checks++;
      if (comandos !== 3'b110 || timeout_serial !== 1'b0) begin
        errors++;
        $display("FAIL tmo_hold%0d: got cmd=%b tmo=%b expected 110 0", k, comandos, timeout_serial);
      end
    end
    passo(1'b1, 8'h84, 1'b0);
    checks++;
    if (comandos !== 3'b100 || timeout_serial !== 1'b0) begin
      errors++;
      $display("FAIL tmo_frame_wins: got cmd=%b tmo=%b expected 100 0", comandos, timeout_serial);
    end
    for (int k = 1; k <= 10; k++) begin
      q_cmd.push_back(k < 10 ? 3'b100 : 3'b000);
      passo(1'b0, 8'h00, 1'b0);
      e = q_cmd.pop_front();
      checks++;
      if (comandos !== e || timeout_serial !== (k == 10)) begin
        errors++;
        $display("FAIL tmo_idle%0d: got cmd=%b tmo=%b expected %b %b", k, comandos, timeout_serial, e, k == 10);
      end
    end
    for (int k = 0; k < 20; k++) begin
      passo(1'b0, 8'h00, 1'b0);
      checks++;
      if (comandos !== 3'b000 || timeout_serial !== 1'b0) begin
        errors++;
        $display("FAIL tmo_repulse%0d: got cmd=%b tmo=%b expected 000 0", k, comandos, timeout_serial);
      end
    end
    checks++;
    if (destino_disponivel !== 1'b1 || destino !== fila[0]) begin
      errors++;
      $display("FAIL tmo_fifo_kept: got disp=%b dest=%0d expected 1 %0d", destino_disponivel, destino, fila[0]);
    end
  endtask

  task automatic test_reset_assincrono;
    passo(1'b1, 8'h01, 1'b0);
    fila.push_back(7'd1);
    passo(1'b1, 8'h87, 1'b0);
    checks++;
    if (comandos !== 3'b111 || destino !== fila[0]) begin
      errors++;
      $display("FAIL areset_pre: got cmd=%b dest=%0d expected 111 %0d", comandos, destino, fila[0]);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({comandos, destino, destino_disponivel, fifo_cheia, erro_quadro, contagem_erros, timeout_serial} !== '0) begin
      errors++;
      $display("FAIL areset_now: got cmd=%b dest=%0d disp=%b cheia=%b erro=%b cnt=%0d tmo=%b expected all 0",
               comandos, destino, destino_disponivel, fifo_cheia, erro_quadro, contagem_erros, timeout_serial);
    end
    erros_esp = 0;
    fila.delete();
    #3;
    reset = 1'b1;
    passo(1'b1, 8'h01, 1'b0);
    fila.push_back(7'd1);
    checks++;
    if (destino !== fila[0] || destino_disponivel !== 1'b1 || fifo_cheia !== 1'b0 || contagem_erros !== cnt_esp()) begin
      errors++;
      $display("FAIL areset_after: got dest=%0d disp=%b cheia=%b cnt=%0d expected %0d 1 0 %0d",
               destino, destino_disponivel, fifo_cheia, contagem_erros, fila[0], cnt_esp());
    end
  endtask

  initial begin
    test_reset();
    test_comandos();
    test_erros();
    test_fifo();
    test_back_to_back();
    test_saturacao();
    test_timeout();
    test_reset_assincrono();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/interpretador_serial_param.md
Name: interpretador_serial_param

Overview:
Parametrised serial command interpreter for SmartCargo. It sits between the UART receiver and the elevator control unit, and decodes received bytes into two things:
- N_CMD command channels, each configurable as level-held or single-cycle pulse.
- Floor-destination requests, which are buffered in a FIFO for the controller.

It adds a frame-valid handshake, frame error detection with a saturating error counter, and a link-loss timeout that drops level commands to 0.

Parameters:
N_CMD, 3, number of command channels (1..7), mapped to byte bits [N_CMD-1:0]
MASCARA_PULSO, 3'b000, per-channel mode; bit i=1 means channel i is pulse mode, 0 means level mode (width N_CMD)
N_ANDARES, 4, number of valid floors (1..127)
FIFO_DEPTH, 4, destination FIFO depth (power of 2, >=2)
TIMEOUT_CICLOS, 0, cycles without a frame before link-loss; 0 disables the timeout
ERR_W, 8, error counter width

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
dados_serial_recebido  input  8  received byte, sampled only when dado_valido=1
dado_valido  input  1  one-cycle strobe: byte is new
destino_consumido  input  1  pop request for FIFO head
comandos  output  N_CMD  command outputs
destino  output  7  FIFO head floor number (first-word fall-through)
destino_disponivel  output  1  FIFO not empty
fifo_cheia  output  1  FIFO full
erro_quadro  output  1  one-cycle pulse on a rejected frame
contagem_erros  output  ERR_W  saturating count of rejected frames
timeout_serial  output  1  one-cycle pulse on link-loss

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FIFO empty, timeout counter 0, error counter 0.
- Frame decode happens only on cycles with dado_valido=1. All effects are registered and appear 1 cycle after the strobe.
- Command frame (bit7=1):
  - Valid only if bits [6:N_CMD] are all 0.
  - Level channel i takes byte bit i and holds it until the next valid command frame or a timeout.
  - Pulse channel i is 1 for exactly one cycle if bit i=1, else 0. Pulse channels are 0 on every cycle without a valid command frame.
- Destination frame (bit7=0): valid only if bits[6:0] < N_ANDARES. A valid frame pushes bits[6:0] into the FIFO.
- Rejected frame (reserved bits set, out-of-range floor, or push while full without a same-cycle pop):
  - No change to comandos or the FIFO.
  - erro_quadro pulses for 1 cycle.
  - contagem_erros increments and saturates at 2^ERR_W-1.
- FIFO rules:
  - destino always shows the head entry; it is 0 when empty.
  - A pop happens on destino_consumido=1 with destino_disponivel=1. destino_consumido while empty is ignored.
  - Full with push and pop in the same cycle: both succeed, occupancy unchanged, no error.
  - Empty with push and pop in the same cycle: the pop is ignored and the push succeeds.
  - Pointers wrap modulo FIFO_DEPTH. fifo_cheia=1 when occupancy equals FIFO_DEPTH.
  - Data written to an empty FIFO is visible on destino 1 cycle after the strobe.
- Timeout (only when TIMEOUT_CICLOS>0):
  - The counter clears on every dado_valido, whether the frame is valid or rejected, and increments otherwise.
  - When it reaches TIMEOUT_CICLOS, all level channels are forced to 0, timeout_serial pulses once, and the counter holds until the next dado_valido. It never re-pulses without an intervening frame.
  - The FIFO is not affected by a timeout.
- Timeout and a frame in the same cycle: the frame wins and no timeout occurs.
- Reset mid-operation: immediate clear of all outputs and FIFO contents, including in-flight pulses.

Test Plan:
1. Defaults (N_CMD=3, MASCARA_PULSO=3'b001): byte 0x87 with valid -> next cycle comandos=3'b111, then bit0 returns to 0 one cycle later while bits 2:1 hold at 1; then 0x80 -> comandos=3'b000.
2. 0x88 (reserved bit3) and then 0x05 with N_ANDARES=4 -> two erro_quadro pulses, contagem_erros=2, comandos and FIFO unchanged.
3. Push floors 1,2,3,0 -> fifo_cheia=1, destino=1; fifth push of 2 -> erro_quadro, count+1; pop four times -> destino sequence 1,2,3,0, then destino_disponivel=0.
4. Full FIFO with push of 3 and destino_consumido in the same cycle -> no error, fifo_cheia stays 1, last entry is 3; pop on empty -> no change.
5. TIMEOUT_CICLOS=10, comandos=3'b110 held -> after 10 idle cycles comandos=0 and timeout_serial pulses once; 20 further idle cycles produce no second pulse; FIFO contents are kept.
6. Drive reset=0 asynchronously mid-pulse and with 2 FIFO entries -> all outputs 0 immediately, destino_disponivel=0, contagem_erros=0.
